systolic_mm_seq: RTL

Parametrised, self-sequencing N×N output-stationary systolic matrix-multiply engine. It generalises the fixed 2×2 array: width, accumulator size and array dimension are parameters. Input skew and per-PE enables are generated internally instead of being driven per-PE from outside. A start/valid/ready/done job protocol sits on top. It computes C = A×W over a streamed inner dimension of length k_len and sits between the operand buffers and the result writeback logic.

---
 rtl/systolic_mm_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/systolic_mm_seq.sv
// Output-stationary N x N systolic matrix multiplier with internal operand skew
// and a start/valid/ready/done job sequencer wrapped around the PE array.
module systolic_mm_seq #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 40,
    parameter int KW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   a_in,
    input  logic [N*DW-1:0]   w_in,
    output logic              busy,
    output logic              done,
    output logic              c_valid,
    output logic [N*N*AW-1:0] c_out
);
    localparam int DCW = $clog2(2 * N);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_len_q, k_cnt_q;
    logic [DCW-1:0] drain_cnt_q;
    logic           job_go, accept, last_beat, drain_end;

    logic [N*DW-1:0] a_row, w_col;
    logic [N-1:0]    vld_row;

    logic signed [DW-1:0] a_pe   [N][N];
    logic signed [DW-1:0] w_pe   [N][N];
    logic                 vld_pe [N][N];
    logic signed [AW-1:0] acc    [N][N];

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [AW-1:0] mac_term(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] w);
        logic signed [2*DW-1:0] prod;
        prod = (2*DW)'(a) * (2*DW)'(w);
        return AW'(prod);
    endfunction

    assign job_go    = (state_q == IDLE) && start && (k_len != '0);
    assign accept    = (state_q == LOAD) && in_valid;
    assign last_beat = accept && (k_cnt_q == k_len_q - KW'(1));
    assign drain_end = (drain_cnt_q == DCW'(2 * N - 2));

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE:  if (job_go) state_d = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_beat) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_end) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            drain_cnt_q <= '0;
            c_valid     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (job_go) begin
                k_len_q <= k_len;
                k_cnt_q <= '0;
                c_valid <= 1'b0;
            end
            if (accept) k_cnt_q <= k_cnt_q + KW'(1);
            if (last_beat) drain_cnt_q <= '0;
            else if (state_q == DRAIN) drain_cnt_q <= drain_cnt_q + DCW'(1);
            if ((state_q == DRAIN) && drain_end) c_valid <= 1'b1;
        end
    end

    // Skew stage: row r of A and column r of W are delayed by r cycles; the tag rides with A.
    for (genvar r = 0; r < N; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign a_row[DW-1:0] = a_in[DW-1:0];
            assign w_col[DW-1:0] = w_in[DW-1:0];
            assign vld_row[0]    = accept;
        end else begin : g_delay
            logic [DW-1:0] a_skw   [r];
            logic [DW-1:0] w_skw   [r];
            logic          vld_skw [r];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < r; j++) begin
                        a_skw[j]   <= '0;
                        w_skw[j]   <= '0;
                        vld_skw[j] <= 1'b0;
                    end
                end else begin
                    a_skw[0]   <= a_in[r*DW +: DW];
                    w_skw[0]   <= w_in[r*DW +: DW];
                    vld_skw[0] <= accept;
                    for (int j = 1; j < r; j++) begin
                        a_skw[j]   <= a_skw[j-1];
                        w_skw[j]   <= w_skw[j-1];
                        vld_skw[j] <= vld_skw[j-1];
                    end
                end
            end

            assign a_row[r*DW +: DW] = a_skw[r-1];
            assign w_col[r*DW +: DW] = w_skw[r-1];
            assign vld_row[r]        = vld_skw[r-1];
        end
    end

    // PE array: operands shift right/down one PE per cycle, accumulate on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_pe[r][c]   <= '0;
                    w_pe[r][c]   <= '0;
                    vld_pe[r][c] <= 1'b0;
                    acc[r][c]    <= '0;
                end
            end
        end else begin
            for (int r = 0; r < N; r++) begin
                a_pe[r][0]   <= a_row[r*DW +: DW];
                vld_pe[r][0] <= vld_row[r];
                w_pe[0][r]   <= w_col[r*DW +: DW];
            end
            for (int r = 0; r < N; r++) begin
                for (int c = 1; c < N; c++) begin
                    a_pe[r][c]   <= a_pe[r][c-1];
                    vld_pe[r][c] <= vld_pe[r][c-1];
                    w_pe[c][r]   <= w_pe[c-1][r];
                end
            end
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (job_go) acc[r][c] <= '0;
                    else if (vld_pe[r][c]) acc[r][c] <= acc[r][c] + mac_term(a_pe[r][c], w_pe[r][c]);
                end
            end
        end
    end

    always_comb begin
        c_out = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                c_out[(r*N+c)*AW +: AW] = acc[r][c];
            end
        end
    end

endmodule
